// File: rtl/rram_train_sequencer.sv
// RRAM crossbar training sequencer.
// Runs two operations on the crossbar:
//   SET   - programs every row in turn with a pulse followed by an idle gap.
//   LEARN - per sample: handshake a label, forward-read all rows, then
//           back-propagate the label into each row with a pulse and a gap.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   set, learn        - single-cycle commands, honoured only while idle
//   train_num         - number of samples for LEARN, sampled with learn
//   sample_valid/_ready, sample_label - label handshake
//   wl, sl, bl        - wordline, selectline and bitline drives
//   set_ph, back_ph, label_ph - phase strobes (at most one high)
//   busy, done        - operation in progress / one-cycle completion pulse
//   sample_cnt        - samples completed in the current LEARN
// All outputs are registered: they are decoded from the next state.
module rram_train_sequencer #(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 6,
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             learn,
  input  logic [CNT_W-1:0] train_num,
  input  logic             sample_valid,
  input  logic [COLS-1:0]  sample_label,
  output logic             sample_ready,
  output logic [ROWS-1:0]  wl,
  output logic [ROWS-1:0]  sl,
  output logic [COLS-1:0]  bl,
  output logic             set_ph,
  output logic             back_ph,
  output logic             label_ph,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned TW = $clog2(PULSE_W + GAP_W + 1);
  localparam logic [TW-1:0] PulseLast = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] GapLast   = TW'(GAP_W - 1);
  localparam logic [RW-1:0] RowLast   = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    StIdle, StSetPulse, StSetGap, StWait, StFwd, StBkPulse, StBkGap, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    row_q, row_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [COLS-1:0]  label_q, label_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  logic [ROWS-1:0]  wl_d, sl_d;
  logic [COLS-1:0]  bl_d;
  logic             set_ph_d, back_ph_d, label_ph_d, busy_d, done_d, ready_d;
  logic [ROWS-1:0]  row_oh;

  assign cnt_inc = cnt_q + 1'b1;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tmr_d   = '0;
    label_d = label_q;
    total_d = total_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (set) begin
          state_d = StSetPulse;
          row_d   = '0;
        end else if (learn) begin
          total_d = train_num;
          cnt_d   = '0;
          state_d = (train_num == '0) ? StDone : StWait;
        end
      end
      StSetPulse: begin
        if (tmr_q == PulseLast) state_d = StSetGap;
        else                    tmr_d   = tmr_q + 1'b1;
      end
      StSetGap: begin
        if (tmr_q == GapLast) begin
          if (row_q == RowLast) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StSetPulse;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StWait: begin
        // sample_ready is high throughout WAIT, so valid alone completes the handshake.
        if (sample_valid && sample_ready) begin
          label_d = sample_label;
          state_d = StFwd;
        end
      end
      StFwd: begin
        if (tmr_q == PulseLast) begin
          state_d = StBkPulse;
          row_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StBkPulse: begin
        if (tmr_q == PulseLast) state_d = StBkGap;
        else                    tmr_d   = tmr_q + 1'b1;
      end
      StBkGap: begin
        if (tmr_q == GapLast) begin
          if (row_q == RowLast) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == total_q) ? StDone : StWait;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = StBkPulse;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so the registered outputs track it.
  always_comb begin
    row_oh     = ROWS'(1) << row_d;
    wl_d       = '0;
    sl_d       = '0;
    bl_d       = '0;
    set_ph_d   = 1'b0;
    back_ph_d  = 1'b0;
    label_ph_d = 1'b0;
    ready_d    = 1'b0;
    done_d     = 1'b0;
    busy_d     = (state_d != StIdle);
    unique case (state_d)
      StSetPulse: begin
        wl_d     = row_oh;
        sl_d     = row_oh;
        bl_d     = '1;
        set_ph_d = 1'b1;
      end
      StWait: ready_d = 1'b1;
      StFwd: begin
        wl_d       = '1;
        label_ph_d = 1'b1;
      end
      StBkPulse: begin
        wl_d      = row_oh;
        sl_d      = row_oh;
        bl_d      = label_d;
        back_ph_d = 1'b1;
      end
      StDone:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      row_q        <= '0;
      tmr_q        <= '0;
      label_q      <= '0;
      total_q      <= '0;
      cnt_q        <= '0;
      wl           <= '0;
      sl           <= '0;
      bl           <= '0;
      set_ph       <= 1'b0;
      back_ph      <= 1'b0;
      label_ph     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_ready <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      tmr_q        <= tmr_d;
      label_q      <= label_d;
      total_q      <= total_d;
      cnt_q        <= cnt_d;
      wl           <= wl_d;
      sl           <= sl_d;
      bl           <= bl_d;
      set_ph       <= set_ph_d;
      back_ph      <= back_ph_d;
      label_ph     <= label_ph_d;
      busy         <= busy_d;
      done         <= done_d;
      sample_ready <= ready_d;
    end
  end

  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_rram_train_sequencer.sv
module tb_rram_train_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       set, learn;
  logic [7:0] train_num;
  logic       sample_valid;
  logic [5:0] sample_label;
  logic       sample_ready;
  logic [5:0] wl, sl, bl;
  logic       set_ph, back_ph, label_ph, busy, done;
  logic [7:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  rram_train_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .set          (set),
    .learn        (learn),
    .train_num    (train_num),
    .sample_valid (sample_valid),
    .sample_label (sample_label),
    .sample_ready (sample_ready),
    .wl           (wl),
    .sl           (sl),
    .bl           (bl),
    .set_ph       (set_ph),
    .back_ph      (back_ph),
    .label_ph     (label_ph),
    .busy         (busy),
    .done         (done),
    .sample_cnt   (sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        set;
    logic        learn;
    logic [7:0]  tn;
    logic        valid;
    logic [5:0]  label;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  // {wl, sl, bl, set_ph, back_ph, label_ph, busy, done, ready, cnt}
  function automatic logic [31:0] pk(input logic [5:0] w, input logic [5:0] s,
                                     input logic [5:0] b, input logic sp, input logic bp,
                                     input logic lp, input logic bz, input logic dn,
                                     input logic rd, input logic [7:0] c);
    return {w, s, b, sp, bp, lp, bz, dn, rd, c};
  endfunction

  task automatic check(input string name, input logic [31:0] exp);
    logic [31:0] got;
    got = {wl, sl, bl, set_ph, back_ph, label_ph, busy, done, sample_ready, sample_cnt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      set          = vecs[i].set;
      learn        = vecs[i].learn;
      train_num    = vecs[i].tn;
      sample_valid = vecs[i].valid;
      sample_label = vecs[i].label;
      step();
      set          = 1'b0;
      learn        = 1'b0;
      sample_valid = 1'b0;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
  endtask

  // SET run: cycle c in 1..36 is row (c-1)/6, pulse on the first 4 of every 6.
  task automatic set_seq(input bit with_learn, input bit poke, input logic [7:0] cnt);
    logic [31:0] exp;
    logic [5:0]  oh;
    int r, p;
    for (int c = 1; c <= 38; c++) begin
      set       = (c == 1) || (poke && c == 12);
      learn     = with_learn && (c == 1);
      train_num = 8'd3;
      step();
      set   = 1'b0;
      learn = 1'b0;
      if (c <= 36) begin
        r  = (c - 1) / 6;
        p  = (c - 1) % 6;
        oh = 6'd1 << r;
        exp = (p < 4) ? pk(oh, oh, 6'h3F, 1, 0, 0, 1, 0, 0, cnt)
                      : pk(0, 0, 0, 0, 0, 0, 1, 0, 0, cnt);
      end else if (c == 37) begin
        exp = pk(0, 0, 0, 0, 0, 0, 1, 1, 0, cnt);
      end else begin
        exp = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, cnt);
      end
      check($sformatf("set c%0d", c), exp);
    end
  endtask

  // One full sample starting from WAIT; newcnt is sample_cnt after it completes.
  task automatic do_sample(input logic [5:0] label, input logic [7:0] newcnt, input bit last);
    logic [5:0] oh;
    sample_valid = 1'b1;
    sample_label = label;
    for (int k = 0; k < 4; k++) begin
      step();
      sample_valid = 1'b0;
      check($sformatf("fwd%0d s%0d", k, newcnt),
            pk(6'h3F, 0, 0, 0, 0, 1, 1, 0, 0, newcnt - 8'd1));
    end
    for (int r = 0; r < 6; r++) begin
      oh = 6'd1 << r;
      for (int p = 0; p < 6; p++) begin
        step();
        check($sformatf("bk r%0d p%0d s%0d", r, p, newcnt),
              (p < 4) ? pk(oh, oh, label, 0, 1, 0, 1, 0, 0, newcnt - 8'd1)
                      : pk(0, 0, 0, 0, 0, 0, 1, 0, 0, newcnt - 8'd1));
      end
    end
    step();
    if (last) check("sample done", pk(0, 0, 0, 0, 0, 0, 1, 1, 0, newcnt));
    else      check("sample next", pk(0, 0, 0, 0, 0, 0, 1, 0, 1, newcnt));
  endtask

  localparam logic [31:0] Zero = 32'h0;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'd0, 1'b0, 6'd0, Zero};
    vecs[1] = '{1'b0, 1'b0, 8'd0, 1'b0, 6'd0, Zero};
    vecs[2] = '{1'b0, 1'b0, 8'd0, 1'b0, 6'd0, Zero};
    vecs[3] = '{1'b0, 1'b0, 8'd0, 1'b0, 6'd0, Zero};
    vecs[4] = '{1'b0, 1'b0, 8'd0, 1'b0, 6'd0, Zero};
    // learn with zero samples: done next cycle, count cleared
    vecs[5] = '{1'b0, 1'b1, 8'd0, 1'b0, 6'd0, pk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0)};
    vecs[6] = '{1'b0, 1'b0, 8'd0, 1'b0, 6'd0, Zero};
    // valid outside WAIT is ignored
    vecs[7] = '{1'b0, 1'b0, 8'd0, 1'b1, 6'h3F, Zero};
    vecs[8] = '{1'b0, 1'b0, 8'd0, 1'b0, 6'd0, Zero};

    reset        = 1'b1;
    set          = 1'b0;
    learn        = 1'b0;
    train_num    = 8'd0;
    sample_valid = 1'b0;
    sample_label = 6'd0;
    step();
    step();
    check("in reset", Zero);
    reset = 1'b0;
    apply_vecs(0, 4);

    set_seq(1'b0, 1'b0, 8'd0);
    // set+learn together: SET only; extra set mid-run ignored
    set_seq(1'b1, 1'b1, 8'd0);

    // learn two samples
    learn     = 1'b1;
    train_num = 8'd2;
    step();
    learn = 1'b0;
    check("learn wait0", pk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    step();
    check("learn wait1", pk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    do_sample(6'b101001, 8'd1, 1'b0);
    do_sample(6'b010110, 8'd2, 1'b1);
    step();
    check("learn idle cnt hold", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd2));
    step();
    check("learn idle cnt hold2", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd2));
    apply_vecs(5, 8);

    // stall in WAIT, then abort in BK row 3
    learn     = 1'b1;
    train_num = 8'd5;
    step();
    learn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("stall%0d", i), pk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    end
    sample_valid = 1'b1;
    sample_label = 6'b110011;
    step();
    sample_valid = 1'b0;
    for (int i = 0; i < 3 + 18 + 2; i++) step();
    check("abort pre", pk(6'h08, 6'h08, 6'b110011, 0, 1, 0, 1, 0, 0, 0));
    #2 reset = 1'b1;
    #1 check("abort async", Zero);
    step();
    step();
    check("abort held", Zero);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post abort%0d", i), Zero);
    end
    set_seq(1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rram_train_sequencer.md
Name: rram_train_sequencer

Overview:
- Sequences the 6x6 RRAM crossbar through two operations: array SET (initialise every row) and LEARN (per-sample forward read, then row-by-row back-propagation update pulses).
- Sits between the application top level, which issues single-cycle `set`/`learn` commands, and the crossbar line drivers (wordline, selectline, bitline and phase strobes).
- Training samples arrive over a valid/ready handshake carrying a label vector.

Parameters:
- ROWS, 6, number of wordline/selectline rows.
- COLS, 6, number of bitlines; also the label width.
- PULSE_W, 4, cycles per programming/read pulse (>=1).
- GAP_W, 2, idle cycles after each programming pulse (>=1).
- CNT_W, 8, width of the training-sample count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- set  input  1  single-cycle request to run the array SET operation.
- learn  input  1  single-cycle request to run LEARN; `train_num` is sampled on the same edge.
- train_num  input  CNT_W  number of samples to train.
- sample_valid  input  1  a sample label is available.
- sample_label  input  COLS  label for the current sample.
- sample_ready  output  1  sequencer accepts a sample this cycle.
- wl  output  ROWS  wordline enables.
- sl  output  ROWS  selectline enables.
- bl  output  COLS  bitline drive.
- set_ph  output  1  SET-phase strobe.
- back_ph  output  1  back-propagation update strobe.
- label_ph  output  1  forward/label read strobe.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when an operation completes.
- sample_cnt  output  CNT_W  samples completed in the current LEARN.

Behaviour:
- Reset:
  - All outputs 0 and state IDLE.
  - Reset asserted mid-operation aborts immediately (asynchronously): lines drop to 0 and no `done` is issued.
- Output timing:
  - All outputs are registered.
  - A command sampled at edge k produces its first line activity in cycle k+1.
- States: IDLE, SET_PULSE, SET_GAP, WAIT, FWD, BK_PULSE, BK_GAP, DONE.
- IDLE:
  - `set`=1 -> SET_PULSE with row=0.
  - Otherwise, `learn`=1 -> latch `train_num` and clear `sample_cnt`.
    - Latched count 0 -> go directly to DONE.
    - Otherwise -> WAIT.
  - `set` and `learn` together: `set` wins and `learn` is dropped.
  - `set`/`learn` outside IDLE are ignored.
- SET_PULSE:
  - Drives wl=sl=one-hot(row), bl=all ones, set_ph=1 for PULSE_W cycles.
  - Then SET_GAP: all lines 0 for GAP_W cycles.
  - Then row+1. After row ROWS-1, -> DONE.
  - Total SET time = ROWS*(PULSE_W+GAP_W) cycles.
- WAIT:
  - sample_ready=1. Lines are 0.
  - A transfer occurs on an edge where sample_valid && sample_ready: `sample_label` is latched -> FWD.
  - No timeout; sample_valid may be held low indefinitely.
- FWD:
  - Drives wl=all ones, sl=0, bl=0, label_ph=1 for PULSE_W cycles -> BK_PULSE with row=0.
- BK_PULSE:
  - Drives wl=sl=one-hot(row), bl=latched label, back_ph=1 for PULSE_W cycles.
  - Then BK_GAP: all lines 0 for GAP_W cycles, then row+1.
  - After row ROWS-1: `sample_cnt` increments.
    - If equal to latched count -> DONE.
    - Otherwise -> WAIT.
- Per-sample time after handshake: PULSE_W + ROWS*(PULSE_W+GAP_W).
- DONE: done=1 for exactly one cycle; busy still 1; -> IDLE.
- busy=1 in every state except IDLE.
- Invariants:
  - At most one of set_ph/back_ph/label_ph is high in any cycle.
  - wl is one-hot in SET_PULSE and BK_PULSE.
  - sample_cnt holds its final value after DONE until the next `learn`.
  - sample_cnt never wraps (count <= 2^CNT_W-1).

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, sample_ready=0.
- set pulse at edge 0 (defaults):
  - 6 pulses; row r has wl=sl=1<<r, bl=6'b111111, set_ph high in cycles 6r+1..6r+4.
  - done=1 at cycle 37; busy=1 in cycles 1..37.
- learn with train_num=2, labels 6'b101001 then 6'b010110, each presented one cycle after sample_ready:
  - Each sample gives 4 cycles label_ph with wl=6'h3F.
  - Then 6 back_ph pulses with bl equal to that sample's label.
  - done after the second sample; sample_cnt=2.
- learn with train_num=0 -> done one cycle later; no line activity; sample_ready never high.
- set and learn asserted together -> SET sequence only. set pulsed mid-SET -> ignored; exactly one done.
- Stall and abort:
  - Hold sample_valid low 20 cycles in WAIT -> sample_ready stays 1 and lines stay 0.
  - Assert reset during BK_PULSE row 3 -> all outputs 0 immediately; no done.
  - A subsequent set runs normally.
